// File: rtl/hazard_stall_ctrl_if.sv
// Hazard/stall control bundle between the 5-stage pipeline datapath and its sequencer.
// Master is the pipeline side, which reports hazard sources. Slave is the sequencer, which drives the stage controls.
interface hazard_stall_ctrl_if #(
  parameter int unsigned CNT_WIDTH = 16
);
  logic [4:0]           IF_ID_rs1_i;
  logic [4:0]           IF_ID_rs2_i;
  logic                 id_uses_rs1_i;
  logic                 id_uses_rs2_i;
  logic                 ID_EX_mem_read_i;
  logic [4:0]           ID_EX_rd_i;
  logic                 branch_taken_i;
  logic                 jalr_i;
  logic                 dmem_req_i;
  logic                 dmem_ready_i;
  logic                 pc_write_o;
  logic                 pc_redirect_o;
  logic                 IF_ID_write_o;
  logic                 IF_ID_flush_o;
  logic                 ID_EX_write_o;
  logic                 ID_EX_bubble_o;
  logic                 EX_MEM_write_o;
  logic                 MEM_WB_bubble_o;
  logic                 mem_timeout_o;
  logic [CNT_WIDTH-1:0] stall_count_o;
  logic [CNT_WIDTH-1:0] flush_count_o;
  logic [1:0]           state_o;

  modport master (
    output IF_ID_rs1_i, IF_ID_rs2_i, id_uses_rs1_i, id_uses_rs2_i, ID_EX_mem_read_i,
           ID_EX_rd_i, branch_taken_i, jalr_i, dmem_req_i, dmem_ready_i,
    input  pc_write_o, pc_redirect_o, IF_ID_write_o, IF_ID_flush_o, ID_EX_write_o,
           ID_EX_bubble_o, EX_MEM_write_o, MEM_WB_bubble_o, mem_timeout_o,
           stall_count_o, flush_count_o, state_o
  );

  modport slave (
    input  IF_ID_rs1_i, IF_ID_rs2_i, id_uses_rs1_i, id_uses_rs2_i, ID_EX_mem_read_i,
           ID_EX_rd_i, branch_taken_i, jalr_i, dmem_req_i, dmem_ready_i,
    output pc_write_o, pc_redirect_o, IF_ID_write_o, IF_ID_flush_o, ID_EX_write_o,
           ID_EX_bubble_o, EX_MEM_write_o, MEM_WB_bubble_o, mem_timeout_o,
           stall_count_o, flush_count_o, state_o
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencer for the RV32I core. It handles load-use stalls, EX redirects with squash cycles,
// and dmem wait states. It also keeps saturating stall and flush counters.
module hazard_stall_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT  = 255,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input logic               clk,
  input logic               reset,
  hazard_stall_ctrl_if.slave bus
);
  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, FLUSH = 2'd2} state_t;

  localparam logic [3:0] FLUSH_RELOAD = (FLUSH_CYCLES > 0) ? 4'(FLUSH_CYCLES - 1) : 4'd0;
  localparam logic [7:0] TIMEOUT_LIM  = 8'(MEM_TIMEOUT);

  state_t               state, state_nxt, ret_state, ret_nxt, phase;
  logic [3:0]           flush_cnt, flush_cnt_nxt;
  logic [7:0]           wait_cnt, wait_nxt;
  logic                 mem_timeout, timeout_nxt;
  logic [CNT_WIDTH-1:0] stall_count, flush_count;
  logic                 hold, redirect, load_use, flush_inc;

  assign redirect = bus.branch_taken_i | bus.jalr_i;
  assign load_use = bus.ID_EX_mem_read_i && (bus.ID_EX_rd_i != 5'd0) &&
                    ((bus.id_uses_rs1_i && (bus.IF_ID_rs1_i == bus.ID_EX_rd_i)) ||
                     (bus.id_uses_rs2_i && (bus.IF_ID_rs2_i == bus.ID_EX_rd_i)));
  assign hold  = (state == MEM_WAIT) ? !bus.dmem_ready_i : (bus.dmem_req_i && !bus.dmem_ready_i);
  // On the release cycle, the state saved at entry is evaluated. This lets a pending redirect or flush resume immediately.
  assign phase = (state == MEM_WAIT) ? ret_state : state;

  always_comb begin
    bus.pc_write_o      = 1'b1;
    bus.pc_redirect_o   = 1'b0;
    bus.IF_ID_write_o   = 1'b1;
    bus.IF_ID_flush_o   = 1'b0;
    bus.ID_EX_write_o   = 1'b1;
    bus.ID_EX_bubble_o  = 1'b0;
    bus.EX_MEM_write_o  = 1'b1;
    bus.MEM_WB_bubble_o = 1'b0;
    state_nxt     = state;
    ret_nxt       = ret_state;
    flush_cnt_nxt = flush_cnt;
    wait_nxt      = wait_cnt;
    timeout_nxt   = mem_timeout;
    flush_inc     = 1'b0;
    if (reset) begin
      bus.pc_write_o      = 1'b0;
      bus.IF_ID_write_o   = 1'b0;
      bus.ID_EX_write_o   = 1'b0;
      bus.EX_MEM_write_o  = 1'b0;
      bus.IF_ID_flush_o   = 1'b1;
      bus.ID_EX_bubble_o  = 1'b1;
      bus.MEM_WB_bubble_o = 1'b1;
      state_nxt     = RUN;
      ret_nxt       = RUN;
      flush_cnt_nxt = '0;
      wait_nxt      = '0;
      timeout_nxt   = 1'b0;
    end else if (hold) begin
      bus.pc_write_o      = 1'b0;
      bus.IF_ID_write_o   = 1'b0;
      bus.ID_EX_write_o   = 1'b0;
      bus.EX_MEM_write_o  = 1'b0;
      bus.MEM_WB_bubble_o = 1'b1;
      if (state != MEM_WAIT) begin
        ret_nxt   = state;
        state_nxt = MEM_WAIT;
      end
      if (wait_cnt != 8'hFF) wait_nxt = wait_cnt + 8'd1;
      if (wait_nxt >= TIMEOUT_LIM) timeout_nxt = 1'b1;
    end else begin
      wait_nxt  = '0;
      state_nxt = phase;
      if (redirect) begin
        bus.pc_redirect_o  = 1'b1;
        bus.IF_ID_flush_o  = 1'b1;
        bus.ID_EX_bubble_o = 1'b1;
        flush_inc     = 1'b1;
        flush_cnt_nxt = FLUSH_RELOAD;
        state_nxt     = (FLUSH_CYCLES > 0) ? FLUSH : RUN;
      end else if (phase == FLUSH) begin
        bus.IF_ID_flush_o  = 1'b1;
        bus.ID_EX_bubble_o = 1'b1;
        if (flush_cnt == 4'd0) state_nxt = RUN;
        else flush_cnt_nxt = flush_cnt - 4'd1;
      end else if (load_use) begin
        bus.pc_write_o     = 1'b0;
        bus.IF_ID_write_o  = 1'b0;
        bus.ID_EX_bubble_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (!bus.pc_write_o && (stall_count != '1)) stall_count <= stall_count + 1'b1;
      if (flush_inc && (flush_count != '1)) flush_count <= flush_count + 1'b1;
    end
    state       <= state_nxt;
    ret_state   <= ret_nxt;
    flush_cnt   <= flush_cnt_nxt;
    wait_cnt    <= wait_nxt;
    mem_timeout <= timeout_nxt;
  end

  assign bus.mem_timeout_o = mem_timeout;
  assign bus.stall_count_o = stall_count;
  assign bus.flush_count_o = flush_count;
  assign bus.state_o       = state;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl. It drives directed hazard scenarios followed by random traffic.
// Each cycle is checked against a cycle-level behavioural model.
module tb_hazard_stall_ctrl;
  localparam int FC  = 2;
  localparam int MT  = 3;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_stall_ctrl_if #(.CNT_WIDTH(CW)) bus ();
  hazard_stall_ctrl #(.FLUSH_CYCLES(FC), .MEM_TIMEOUT(MT), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // Model: waiting holds the pipeline, and flushing/left persist frozen across a wait.
  bit m_wait, m_flushing, m_timeout;
  int m_left, m_wait_len, m_stalls, m_flushes;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic mr, input logic [4:0] rd,
                       input logic bt, input logic jl, input logic req, input logic rdy);
    reset = r;
    bus.IF_ID_rs1_i = rs1;      bus.IF_ID_rs2_i = rs2;
    bus.id_uses_rs1_i = u1;     bus.id_uses_rs2_i = u2;
    bus.ID_EX_mem_read_i = mr;  bus.ID_EX_rd_i = rd;
    bus.branch_taken_i = bt;    bus.jalr_i = jl;
    bus.dmem_req_i = req;       bus.dmem_ready_i = rdy;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Inputs are already driven for this cycle. Check against the model, then advance to one unit past the next edge.
  task automatic step();
    logic [7:0] ctl, obs;
    int exp_state;
    bit lu;
    #1;
    exp_state = m_wait ? 1 : (m_flushing ? 2 : 0);
    check("state", 32'(bus.state_o), 32'(exp_state));
    check("stall_count", 32'(bus.stall_count_o), 32'((m_stalls > SAT) ? SAT : m_stalls));
    check("flush_count", 32'(bus.flush_count_o), 32'((m_flushes > SAT) ? SAT : m_flushes));
    check("mem_timeout", 32'(bus.mem_timeout_o), 32'(m_timeout));
    lu = bus.ID_EX_mem_read_i && bus.ID_EX_rd_i != 0 &&
         ((bus.id_uses_rs1_i && bus.IF_ID_rs1_i == bus.ID_EX_rd_i) ||
          (bus.id_uses_rs2_i && bus.IF_ID_rs2_i == bus.ID_EX_rd_i));
    // ctl = {pc_write, pc_redirect, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_bubble, EX_MEM_write, MEM_WB_bubble}
    if (reset) begin
      ctl = 8'b0001_0101;
      m_wait = 0; m_flushing = 0; m_timeout = 0;
      m_left = 0; m_wait_len = 0; m_stalls = 0; m_flushes = 0;
    end else if (m_wait ? !bus.dmem_ready_i : (bus.dmem_req_i && !bus.dmem_ready_i)) begin
      ctl = 8'b0000_0001;
      m_wait = 1;
      m_wait_len++;
      if (m_wait_len >= MT) m_timeout = 1;
      m_stalls++;
    end else begin
      m_wait = 0;
      m_wait_len = 0;
      ctl = 8'b1010_1010;
      if (bus.branch_taken_i || bus.jalr_i) begin
        ctl = 8'b1111_1110;
        m_flushes++;
        m_flushing = (FC > 0);
        m_left = FC - 1;
      end else if (m_flushing) begin
        ctl = 8'b1011_1110;
        if (m_left == 0) m_flushing = 0;
        else m_left--;
      end else if (lu) begin
        ctl = 8'b0000_1110;
        m_stalls++;
      end
    end
    obs = {bus.pc_write_o, bus.pc_redirect_o, bus.IF_ID_write_o, bus.IF_ID_flush_o,
           bus.ID_EX_write_o, bus.ID_EX_bubble_o, bus.EX_MEM_write_o, bus.MEM_WB_bubble_o};
    check("controls", 32'(obs), 32'(ctl));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      idle();
      reset = 1'b1;
      step();
    end
    idle();
  endtask

  initial begin
    idle();
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Reset held for three cycles, then released.
    do_reset(3);
    check("rst_state", 32'(bus.state_o), 32'd0);
    check("rst_stalls", 32'(bus.stall_count_o), 32'd0);
    step();

    // Load-use on rs2 = x5, then the same pattern with rd = x0.
    drive(1'b0, 5'd1, 5'd5, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check("lu_stall_count", 32'(bus.stall_count_o), 32'd1);
    drive(1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check("lu_x0_no_stall", 32'(bus.stall_count_o), 32'd1);

    // A branch-taken pulse gives a redirect cycle followed by two flush cycles.
    do_reset(1);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    check("br_state_flush", 32'(bus.state_o), 32'd2);
    idle(); step(); step();
    check("br_state_run", 32'(bus.state_o), 32'd0);
    check("br_flush_count", 32'(bus.flush_count_o), 32'd1);

    // The dmem wait holds for four cycles and is released on the fifth.
    do_reset(1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      step();
    end
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    check("mw_stall_count", 32'(bus.stall_count_o), 32'd4);
    check("mw_state_run", 32'(bus.state_o), 32'd0);

    // Redirect during a wait fires on the ready cycle. Load-use together with a redirect yields the redirect only.
    do_reset(1);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    check("rw_state_wait", 32'(bus.state_o), 32'd1);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    step();
    check("rw_flush_count", 32'(bus.flush_count_o), 32'd1);
    idle(); step(); step();
    drive(1'b0, 5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    check("lu_br_stalls", 32'(bus.stall_count_o), 32'd1);
    check("lu_br_flushes", 32'(bus.flush_count_o), 32'd2);
    idle(); step(); step();

    // The timeout sets after three wait cycles. A reset in the middle of the wait clears it.
    do_reset(1);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(); step();
    check("to_not_yet", 32'(bus.mem_timeout_o), 32'd0);
    step();
    check("to_set", 32'(bus.mem_timeout_o), 32'd1);
    check("to_state_wait", 32'(bus.state_o), 32'd1);
    reset = 1'b1;
    step();
    check("to_rst_state", 32'(bus.state_o), 32'd0);
    check("to_rst_clear", 32'(bus.mem_timeout_o), 32'd0);

    // Random traffic, which also drives the counters into saturation.
    idle();
    for (int i = 0; i < 1500; i++) begin
      drive(($urandom_range(0, 59) == 0),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom), 1'($urandom), 1'($urandom),
            5'($urandom_range(0, 3)),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
